// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// FSM state encoding, Booth digit encoding and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_e;

    // Unsigned operands carry two extra zero bits so the top Booth digit
    // never reads a sign bit, which costs one more iteration.
    function automatic int calc_iter(input int width, input bit is_signed);
        return is_signed ? width / 2 : width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: three overlapping multiplier bits select one of
// {0, +A, +2A, -A, -2A}. A arrives already sign/zero-extended to WIDTH+2
// bits, which is wide enough that the doubled and negated copies never wrap.
module booth_r4_enc
    import booth_pkg::*;
#(
    parameter int WIDTH = 192
) (
    input  logic [2:0]       i_bits,
    input  logic [WIDTH+1:0] i_a,
    output booth_digit_e     o_digit,
    output logic [WIDTH+1:0] o_mult
);

    localparam int AW = WIDTH + 2;

    logic [AW-1:0] w_a2;
    assign w_a2 = {i_a[AW-2:0], 1'b0};

    // Recode the bit triplet and pick the matching multiple of A
    always_comb begin
        o_digit = ZERO;
        o_mult  = '0;
        case (i_bits)
            3'b001, 3'b010: o_digit = POS1;
            3'b011:         o_digit = POS2;
            3'b100:         o_digit = NEG2;
            3'b101, 3'b110: o_digit = NEG1;
            default:        o_digit = ZERO;
        endcase
        case (o_digit)
            POS1:    o_mult = i_a;
            POS2:    o_mult = w_a2;
            NEG1:    o_mult = '0 - i_a;
            NEG2:    o_mult = '0 - w_a2;
            default: o_mult = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Optional macro BOOTH_R4_OUT_REG_EN adds one register stage on c/done.
// The running product is {r_acc, r_mul}: the accumulator shifts right by
// two each cycle and its low bits fill the multiplier register as the
// multiplier bits are consumed, so after the last step the register pair
// holds the full product.
module booth_r4_seq
    import booth_pkg::*;
#(
    parameter int WIDTH  = 192,
    parameter bit SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);

    localparam int ITER = calc_iter(WIDTH, SIGNED);
    localparam int AW   = WIDTH + 2;
    localparam int MW   = 2 * ITER;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PHI  = 2 * WIDTH - MW;

    state_e             r_state;
    logic [AW-1:0]      r_a;
    logic [AW-1:0]      r_acc;
    logic [MW-1:0]      r_mul;
    logic               r_prev;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_c;

    logic [AW-1:0]      w_a_ext;
    logic [MW-1:0]      w_b_ext;
    booth_digit_e       w_digit;
    logic [AW-1:0]      w_mult;
    logic [AW-1:0]      w_sum;
    logic [AW-1:0]      w_acc_nxt;
    logic [MW-1:0]      w_mul_nxt;
    logic [2*WIDTH-1:0] w_prod;

    generate
        if (SIGNED) begin : g_sgn
            assign w_a_ext = {{2{a[WIDTH-1]}}, a};
            assign w_b_ext = b;
        end else begin : g_uns
            assign w_a_ext = {2'b00, a};
            assign w_b_ext = {2'b00, b};
        end
    endgenerate

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .i_bits  ({r_mul[1:0], r_prev}),
        .i_a     (r_a),
        .o_digit (w_digit),
        .o_mult  (w_mult)
    );

    // Partial sums stay within [-2A, 2A), so WIDTH+2 bits never overflow
    assign w_sum     = (w_digit == ZERO) ? r_acc : r_acc + w_mult;
    assign w_acc_nxt = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_mul_nxt = {w_sum[1:0], r_mul[MW-1:2]};
    assign w_prod    = {w_acc_nxt[PHI-1:0], w_mul_nxt};

    // Control FSM and datapath registers; DONE can chain straight into CALC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_mul   <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_a     <= w_a_ext;
                        r_mul   <= w_b_ext;
                        r_prev  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= CW'(ITER - 1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_acc  <= w_acc_nxt;
                    r_mul  <= w_mul_nxt;
                    r_prev <= r_mul[1];
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_c     <= w_prod;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;

`ifdef BOOTH_R4_OUT_REG_EN
    logic               r_done_q;
    logic [2*WIDTH-1:0] r_c_q;

    // Extra output stage: adds one cycle of latency, not a throughput bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q <= 1'b0;
            r_c_q    <= '0;
        end else begin
            r_done_q <= r_done;
            r_c_q    <= r_c;
        end
    end

    assign done = r_done_q;
    assign c    = r_c_q;
`else
    assign done = r_done;
    assign c    = r_c;
`endif

endmodule

// File: tb/tb_booth_r4_seq.sv
// Self-checking bench for booth_r4_seq: one signed and one unsigned
// instance at WIDTH=192, checked against a plain wide-multiply model.
module tb_booth_r4_seq;

    localparam int W    = 192;
    localparam int IT_S = W / 2;
    localparam int IT_U = W / 2 + 1;
`ifdef BOOTH_R4_OUT_REG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_s = 1'b0;
    logic           start_u = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy_s, done_s, busy_u, done_u;
    logic [2*W-1:0] c_s, c_u;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] ea [0:419];
    logic [W-1:0] eb [0:419];

    always #5 clk = ~clk;

    booth_r4_seq #(.WIDTH(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .c(c_s)
    );

    booth_r4_seq #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .c(c_u)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input bit sgn);
        logic [2*W-1:0] xe, ye;
        xe = {{W{sgn & x[W-1]}}, x};
        ye = {{W{sgn & y[W-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; operands are scrambled every cycle after acceptance and
    // an optional stray start is pulsed at CALC cycle 'glitch'.
    task automatic run_op(input string tag, input bit sgn, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int glitch);
        int             lat, bcnt;
        logic [2*W-1:0] res, exp_c;
        exp_c = ref_mul(x, y, sgn);
        res   = 'x;
        a = x; b = y;
        if (sgn) start_s = 1'b1; else start_u = 1'b1;
        tick();
        start_s = 1'b0; start_u = 1'b0;
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            a = rnd(); b = rnd();
            if (k == glitch) begin
                if (sgn) start_s = 1'b1; else start_u = 1'b1;
            end
            tick();
            start_s = 1'b0; start_u = 1'b0;
            if (sgn ? busy_s : busy_u) bcnt++;
            if (sgn ? done_s : done_u) begin
                lat = k;
                res = sgn ? c_s : c_u;
            end
        end
        chk({tag, "_lat"}, lat, sgn ? IT_S + XL : IT_U + XL);
        chk({tag, "_busy"}, bcnt, sgn ? IT_S - 1 : IT_U - 1);
        chk({tag, "_c"}, res, exp_c);
        tick();
        chk({tag, "_pulse"}, sgn ? done_s : done_u, 0);
        chk({tag, "_hold"}, sgn ? c_s : c_u, exp_c);
    endtask

    initial begin
        int             ndone, nexp, ae;
        logic [W-1:0]   mn;
        logic [2*W-1:0] big;

        // reset state
        #12;
        chk("rst_busy_s", busy_s, 0);
        chk("rst_done_s", done_s, 0);
        chk("rst_c_s", c_s, 0);
        chk("rst_busy_u", busy_u, 0);
        chk("rst_done_u", done_u, 0);
        chk("rst_c_u", c_u, 0);
        #5 rst = 1'b1;
        tick();

        // directed corners
        run_op("s3x5", 1'b1, W'(3), W'(5), -1);
        chk("s3x5_const", c_s, 15);
        run_op("sm1", 1'b1, '1, '1, -1);
        chk("sm1_const", c_s, 1);
        mn = '0; mn[W-1] = 1'b1;
        run_op("smin", 1'b1, mn, mn, -1);
        big = '0; big[2*W-2] = 1'b1;
        chk("smin_const", c_s, big);
        run_op("umax", 1'b0, '1, '1, -1);
        big = (2*W)'(1) - ((2*W)'(1) << (W + 1));
        chk("umax_const", c_u, big);

        // random operands, both signednesses
        for (int i = 0; i < 4; i++) begin
            run_op("srnd", 1'b1, rnd(), rnd(), -1);
            run_op("urnd", 1'b0, rnd(), rnd(), -1);
        end

        // stray start during CALC must be ignored
        run_op("glitch", 1'b1, rnd(), rnd(), 10);
        ndone = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (done_s) ndone++;
        end
        chk("glitch_extra_done", ndone, 0);

        // start held high: chained DONE->CALC operations
        ndone = 0;
        for (int e = 0; e < 420; e++) begin
            a = rnd(); b = rnd();
            ea[e] = a; eb[e] = b;
            start_s = (e < 300);
            tick();
            if (done_s) begin
                ndone++;
                ae = e - IT_S - XL;
                chk("chain_phase", ae % (IT_S + 1), 0);
                if (ae >= 0) chk("chain_c", c_s, ref_mul(ea[ae], eb[ae], 1'b1));
            end
        end
        start_s = 1'b0;
        nexp = 0;
        for (int t = 0; t < 300; t += IT_S + 1) nexp++;
        chk("chain_count", ndone, nexp);

        // reset in the middle of CALC
        a = rnd(); b = rnd();
        start_s = 1'b1; start_u = 1'b1;
        tick();
        start_s = 1'b0; start_u = 1'b0;
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_c_s", c_s, 0);
        chk("mid_rst_done_s", done_s, 0);
        chk("mid_rst_busy_s", busy_s, 0);
        chk("mid_rst_c_u", c_u, 0);
        chk("mid_rst_busy_u", busy_u, 0);
        #3 rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (done_s || done_u) ndone++;
        end
        chk("post_rst_no_done", ndone, 0);
        run_op("post_rst_s", 1'b1, rnd(), rnd(), -1);
        run_op("post_rst_u", 1'b0, rnd(), rnd(), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
